regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
Owns the single write port of the rv32i register file and shares it between two writeback requesters: port A (ALU result) and port B (load/CSR result).
After reset it runs a clear sequence that zeroes x1..x31. It then grants one writeback per cycle with round-robin arbitration over a valid/ready handshake.
It sits between the execute/memory stages and register_file, and drives write_enable, register_write_select and register_data_write.

Parameters:
XLEN, 32, data width of the register file
NUM_REGS, 32, number of architectural registers; select width is clog2(NUM_REGS)=5
CLEAR_ON_RESET, 1, 1 = run the zeroing sequence after reset; 0 = enter RUN immediately

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
a_valid  input  1  port A has a writeback pending
a_ready  output  1  port A writeback accepted this cycle
a_rd  input  5  port A destination register
a_data  input  XLEN  port A write data
b_valid  input  1  port B has a writeback pending
b_ready  output  1  port B writeback accepted this cycle
b_rd  input  5  port B destination register
b_data  input  XLEN  port B write data
write_enable  output  1  to register_file
register_write_select  output  5  to register_file
register_data_write  output  XLEN  to register_file
init_done  output  1  high once the clear sequence has completed

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: write_enable=0, register_write_select=0, register_data_write=0, init_done=0, state=CLEAR (RUN if CLEAR_ON_RESET=0), clear_idx=1, last_grant=B (so A wins the first tie).
- a_ready and b_ready are combinational. Both are 0 in CLEAR and while reset is asserted.
- State CLEAR:
  - Each cycle after reset release, register write_enable=1, register_write_select=clear_idx, register_data_write=0, then increment clear_idx.
  - The cycle that issues clear_idx=NUM_REGS-1 transitions to RUN.
  - init_done rises on the same edge that enters RUN.
  - Total: 31 write cycles, on cycles 1..31 after reset deassert.
  - Requests arriving during CLEAR are held off (ready=0). Requesters must keep valid, rd and data stable until their ready is seen.
- State RUN, grant rules:
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the port not in last_grant. last_grant updates only on an actual grant.
  - Neither valid -> no grant; write_enable=0 next cycle.
- State RUN, transfer and latency:
  - A transfer occurs when valid&ready.
  - On the next rising edge the outputs register: write_enable=1, select=rd, data=data. Latency from acceptance to the register-file write strobe is 1 cycle.
  - Throughput is one write per cycle.
- rd=0: the request is accepted normally (ready=1 and it counts for round-robin), but write_enable stays 0 for that cycle. x0 is never written.
- Output hold: when write_enable=0, register_write_select and register_data_write hold their last values.
- Reset mid-operation: asserting reset at any point, including mid-CLEAR or mid-transfer, immediately forces the reset values. An accepted-but-not-yet-written transfer is discarded. After release the full CLEAR sequence reruns.
- Stall: a non-granted valid port waits with ready=0. Starvation is impossible; the maximum wait is 1 cycle under continuous contention.
- RUN is terminal until the next reset.

Decomposition:
- Shared package rv32i_pkg: XLEN, NUM_REGS, REG_ADDR_W=5, state enum {CLEAR, RUN}, port id constants PORT_A/PORT_B.
- One natural sub-module: rr_arbiter2, a two-request round-robin with last_grant state. It takes req[1:0] and advance, and returns gnt[1:0].
- The FSM, clear counter and output registers stay in the top block.

Test Plan:
- Reset clear: release reset at t0 with no requests -> write_enable=1 for 31 consecutive cycles, select 1..31, data 0. init_done=1 after the select=31 write. write_enable=0 afterwards.
- Held request during CLEAR: a_valid=1, a_rd=5, a_data=0xDEADBEEF from reset release -> a_ready=0 for the whole clear. a_ready=1 in the first RUN cycle. Next cycle: write_enable=1, select=5, data=0xDEADBEEF.
- Contention: both valid continuously (A: rd=3, 0x11111111; B: rd=4, 0x22222222), new data after each grant -> grants alternate A,B,A,B. Writes appear 1 cycle after each grant, 1 per cycle.
- x0 suppression: a_valid=1, a_rd=0, a_data=0x12345678 in RUN -> a_ready=1; next cycle write_enable=0 and the register file x0 still reads 0.
- Reset mid-transfer: accept b_rd=7, 0xCAFEF00D, then assert reset before the next edge -> no write to x7. Outputs read 0 and init_done=0; after release the clear sequence restarts at select=1.
- CLEAR_ON_RESET=0: release reset with a_valid=1, a_rd=9, a_data=0xA5A5A5A5 -> a_ready=1 in the first cycle and init_done=1 immediately. The write of x9 occurs 1 cycle later.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared constants and types for the rv32i register-file writeback path.
package rv32i_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    // Requester identifiers as stored in the round-robin history bit
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. gnt[0] is port A, gnt[1] is port B.
// Grants are only issued while advance is high; history moves on a real grant.
module rr_arbiter2
    import rv32i_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant;

    // Pick the single requester, or on a tie the port that did not win last
    always_comb begin
        gnt = '0;
        if (advance) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == PORT_B) ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    // Remember the winner of the most recent actual grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= PORT_B;
        end else if (|gnt) begin
            last_grant <= gnt[1] ? PORT_B : PORT_A;
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Owner of the register-file write port: zeroes x1..x(NUM_REGS-1) after reset,
// then forwards one writeback per cycle from port A or port B, round-robin.
module regfile_writeback_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN           = rv32i_pkg::XLEN,
    parameter int unsigned NUM_REGS       = rv32i_pkg::NUM_REGS,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [XLEN-1:0]       b_data,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] register_write_select,
    output logic [XLEN-1:0]       register_data_write,
    output logic                  init_done
);

    localparam state_t                  RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    localparam logic [REG_ADDR_W-1:0]   LAST_IDX    = REG_ADDR_W'(NUM_REGS - 1);

    state_t                state;
    logic [REG_ADDR_W-1:0] clear_idx;
    logic [1:0]            gnt;
    logic                  advance;

    // Arbitration is frozen during CLEAR and while reset is held
    assign advance = (state == RUN) && !reset;

    rr_arbiter2 u_rr_arbiter2 (
        .clock   (clock),
        .reset   (reset),
        .req     ({b_valid, a_valid}),
        .advance (advance),
        .gnt     (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    // Clear sequencer and registered write port; x0 writes are accepted but dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                 <= RESET_STATE;
            clear_idx             <= REG_ADDR_W'(1);
            write_enable          <= 1'b0;
            register_write_select <= '0;
            register_data_write   <= '0;
            init_done             <= !CLEAR_ON_RESET;
        end else begin
            case (state)
                CLEAR: begin
                    write_enable          <= 1'b1;
                    register_write_select <= clear_idx;
                    register_data_write   <= '0;
                    clear_idx             <= clear_idx + 1'b1;
                    if (clear_idx == LAST_IDX) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    write_enable <= 1'b0;
                    if (gnt[0]) begin
                        if (a_rd != '0) begin
                            write_enable          <= 1'b1;
                            register_write_select <= a_rd;
                            register_data_write   <= a_data;
                        end
                    end else if (gnt[1]) begin
                        if (b_rd != '0) begin
                            write_enable          <= 1'b1;
                            register_write_select <= b_rd;
                            register_data_write   <= b_data;
                        end
                    end
                end
                default: state <= RESET_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: a behavioural model
// pushes the expected write-port state for every cycle into a scoreboard
// queue; the entry is popped and compared after the clock edge.
module tb_regfile_writeback_arbiter;

    logic        clock;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        write_enable;
    logic [4:0]  register_write_select;
    logic [31:0] register_data_write;
    logic        init_done;

    // Second instance without the clear sequence
    logic        r2;
    logic        a2_valid, a2_ready, b2_ready;
    logic [4:0]  a2_rd;
    logic [31:0] a2_data;
    logic        we2;
    logic [4:0]  sel2;
    logic [31:0] data2;
    logic        init2;

    regfile_writeback_arbiter #(
        .XLEN           (32),
        .NUM_REGS       (32),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .a_valid               (a_valid),
        .a_ready               (a_ready),
        .a_rd                  (a_rd),
        .a_data                (a_data),
        .b_valid               (b_valid),
        .b_ready               (b_ready),
        .b_rd                  (b_rd),
        .b_data                (b_data),
        .write_enable          (write_enable),
        .register_write_select (register_write_select),
        .register_data_write   (register_data_write),
        .init_done             (init_done)
    );

    regfile_writeback_arbiter #(
        .XLEN           (32),
        .NUM_REGS       (32),
        .CLEAR_ON_RESET (1'b0)
    ) dut_noclr (
        .clock                 (clock),
        .reset                 (r2),
        .a_valid               (a2_valid),
        .a_ready               (a2_ready),
        .a_rd                  (a2_rd),
        .a_data                (a2_data),
        .b_valid               (1'b0),
        .b_ready               (b2_ready),
        .b_rd                  (5'd0),
        .b_data                (32'd0),
        .write_enable          (we2),
        .register_write_select (sel2),
        .register_data_write   (data2),
        .init_done             (init2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  sel;
        logic [31:0] data;
        logic        init;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Model state
    bit          m_run;
    int          m_idx;
    bit          m_last;   // 0 = A won last, 1 = B won last
    logic [4:0]  m_sel;
    logic [31:0] m_data;
    bit          m_init;
    bit          last_a, last_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_idx  = 1;
        m_last = 1'b1;
        m_sel  = '0;
        m_data = '0;
        m_init = 1'b0;
    endtask

    // One clock cycle: inputs are already driven. Predict and check the
    // handshake, push the expected write-port state, then compare after the edge.
    task automatic tick(input bit rst_mid);
        exp_t e;
        bit   ea, eb;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (reset) begin
            model_reset();
            e = '{1'b0, 5'd0, 32'd0, 1'b0};
        end else if (!m_run) begin
            e = '{1'b1, 5'(m_idx), 32'd0, (m_idx == 31)};
            m_sel  = 5'(m_idx);
            m_data = '0;
            if (m_idx == 31) begin
                m_run  = 1'b1;
                m_init = 1'b1;
            end
            m_idx++;
        end else begin
            if (a_valid && (!b_valid || m_last)) ea = 1'b1;
            else if (b_valid)                    eb = 1'b1;
            e.we = 1'b0;
            if (ea) begin
                m_last = 1'b0;
                if (a_rd != 0) begin
                    e.we = 1'b1; m_sel = a_rd; m_data = a_data;
                end
            end else if (eb) begin
                m_last = 1'b1;
                if (b_rd != 0) begin
                    e.we = 1'b1; m_sel = b_rd; m_data = b_data;
                end
            end
            e.sel  = m_sel;
            e.data = m_data;
            e.init = m_init;
        end
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        sb.push_back(e);
        if (rst_mid) begin
            reset = 1'b1;
            #1;
            sb.delete();
            model_reset();
            sb.push_back('{1'b0, 5'd0, 32'd0, 1'b0});
            check("async_rst_we", write_enable, 0);
            check("async_rst_init", init_done, 0);
            check("async_rst_bready", b_ready, 0);
        end
        @(posedge clock);
        @(negedge clock);
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check("write_enable", write_enable, e.we);
            check("write_select", register_write_select, e.sel);
            check("write_data", register_data_write, e.data);
            check("init_done", init_done, e.init);
        end
        last_a = ea;
        last_b = eb;
    endtask

    initial begin
        reset    = 1'b1;
        a_valid  = 1'b0; a_rd = '0; a_data = '0;
        b_valid  = 1'b0; b_rd = '0; b_data = '0;
        r2       = 1'b1;
        a2_valid = 1'b0; a2_rd = '0; a2_data = '0;
        model_reset();

        #1;
        check("rst_we", write_enable, 0);
        check("rst_sel", register_write_select, 0);
        check("rst_data", register_data_write, 0);
        check("rst_init", init_done, 0);
        check("rst_aready", a_ready, 0);
        repeat (2) tick(1'b0);

        // Clear sequence with no requests, then idle
        reset = 1'b0;
        repeat (31) tick(1'b0);
        repeat (2) tick(1'b0);

        // Request held across the whole clear sequence
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        repeat (31) tick(1'b0);
        tick(1'b0);
        a_valid = 1'b0;
        tick(1'b0);

        // Continuous contention, fresh data after every grant
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11111111;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h22222222;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0);
            if (last_a) a_data = a_data + 32'h1;
            if (last_b) b_data = b_data + 32'h1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick(1'b0);

        // x0 write is accepted but suppressed, and still moves round-robin
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h12345678;
        tick(1'b0);
        a_rd = 5'd3; a_data = 32'h33333333;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44444444;
        tick(1'b0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick(1'b0);

        // Reset between acceptance and the write edge
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hCAFEF00D;
        tick(1'b1);
        b_valid = 1'b0;
        tick(1'b0);
        reset = 1'b0;
        repeat (31) tick(1'b0);
        tick(1'b0);

        check("sb_drained", sb.size(), 0);

        // Instance without clear: immediate RUN after release
        a2_valid = 1'b1; a2_rd = 5'd9; a2_data = 32'hA5A5A5A5;
        #1;
        check("noclr_rst_aready", a2_ready, 0);
        check("noclr_rst_we", we2, 0);
        r2 = 1'b0;
        #1;
        check("noclr_aready", a2_ready, 1);
        check("noclr_init", init2, 1);
        check("noclr_we_before", we2, 0);
        @(posedge clock);
        @(negedge clock);
        a2_valid = 1'b0;
        check("noclr_we", we2, 1);
        check("noclr_sel", sel2, 9);
        check("noclr_data", data2, 32'hA5A5A5A5);
        @(posedge clock);
        @(negedge clock);
        check("noclr_we_after", we2, 0);
        check("noclr_sel_hold", sel2, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
